// File: rtl/vram_copy_pkg.sv
// Shared types for the VRAM copy/fill engine.
package vram_copy_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic COPY = 1'b0;
  localparam logic FILL = 1'b1;
endpackage

// File: rtl/vram_copy_valid_pipe.sv
// Fixed-depth delay line carrying {valid, dst_addr} alongside the source read latency.
module valid_pipe #(
  parameter int LAT = 1,
  parameter int AW  = 14
) (
  input  logic          cpu_clk,
  input  logic          reset,
  input  logic          in_vld,
  input  logic [AW-1:0] in_addr,
  output logic          out_vld,
  output logic [AW-1:0] out_addr
);
  logic [LAT-1:0]         vld_pipe;
  logic [LAT-1:0][AW-1:0] addr_pipe;

  // Reset drops every in-flight word.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[0]  <= in_vld;
      addr_pipe[0] <= in_addr;
      for (int s = 1; s < LAT; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        addr_pipe[s] <= addr_pipe[s-1];
      end
    end
  end

  assign out_vld  = vld_pipe[LAT-1];
  assign out_addr = addr_pipe[LAT-1];
endmodule

// File: rtl/vram_copy.sv
// Restartable copy/fill engine: image ROM (or constant) into the VGA VRAM write port.
module vram_copy
  import vram_copy_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int SRC_LAT    = 1,
  parameter int AUTO_START = 1
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              pause,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic              dst_wr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst_data,
  output logic              busy,
  output logic              done
);
  state_t              state, nxt;
  logic                mode_q, first_q;
  logic [ADDR_W-1:0]   src_ptr, dst_ptr;
  logic [ADDR_W:0]     len_q, iss_cnt, wr_cnt;
  logic [DATA_W-1:0]   fill_q;
  logic                go, issue, last_iss, last_wr;

  // first_q marks the first cycle out of reset so it can stand in for start.
  assign go       = start | ((AUTO_START != 0) & first_q);
  assign issue    = (state == RUN) & ~pause;
  assign last_iss = issue & (iss_cnt == len_q - (ADDR_W+1)'(1));
  assign last_wr  = dst_wr & (wr_cnt == len_q - (ADDR_W+1)'(1));
  assign src_addr = src_ptr;

  always_ff @(posedge cpu_clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (go) nxt = (length == '0) ? DONE : RUN;
      RUN:     if (last_iss) nxt = DRAIN;
      DRAIN:   if (last_wr) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    src_rd   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    dst_data = '0;
    if (state == RUN) src_rd = issue & (mode_q == COPY);
    if (state == RUN || state == DRAIN) busy = 1'b1;
    if (state == DONE) done = 1'b1;
    if (dst_wr) dst_data = (mode_q == FILL) ? fill_q : src_data;
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      first_q <= 1'b1;
      mode_q  <= COPY;
      fill_q  <= '0;
      len_q   <= '0;
      src_ptr <= '0;
      dst_ptr <= '0;
      iss_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      first_q <= 1'b0;
      if (state == IDLE) begin
        if (go) begin
          mode_q  <= mode;
          fill_q  <= fill_data;
          len_q   <= length;
          src_ptr <= src_base;
          dst_ptr <= dst_base;
          iss_cnt <= '0;
          wr_cnt  <= '0;
        end
      end else begin
        if (issue) begin
          src_ptr <= src_ptr + ADDR_W'(1);
          dst_ptr <= dst_ptr + ADDR_W'(1);
          iss_cnt <= iss_cnt + (ADDR_W+1)'(1);
        end
        if (dst_wr) wr_cnt <= wr_cnt + (ADDR_W+1)'(1);
      end
    end
  end

  valid_pipe #(.LAT(SRC_LAT), .AW(ADDR_W)) u_pipe (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .in_vld  (issue),
    .in_addr (dst_ptr),
    .out_vld (dst_wr),
    .out_addr(dst_addr)
  );
endmodule
